logic_functions: RTL and testbench

- Registered implementation of a fixed three-output Boolean function of four 1-bit inputs x1..x4.
- Computes an AND-OR term g, an OR-AND term h, and their OR f.
- Captures each valid input vector and presents the results one clock later with a valid flag.
- Used as a small combinational-logic leaf in datapaths that need registered, valid-qualified outputs.

---
 rtl/logic_functions.sv | 40 ++++
 tb/tb_logic_functions.sv | 131 +++++++++++++
 2 files changed

// File: rtl/logic_functions.sv
// logic_functions: registered g/h/f Boolean functions of x1..x4 with a valid flag.
module logic_functions (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  output logic out_valid,
  output logic g,
  output logic h,
  output logic f
);
  logic valid_q, g_q, h_q, f_q;
  logic g_d, h_d, f_d;
  assign g_d = (x1 & x3) | (x2 & x4);
  assign h_d = (x1 | ~x3) & (~x2 | x4);
  assign f_d = g_d | h_d;
  // Results only load on accepted vectors, so idle-cycle inputs never disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      g_q     <= 1'b0;
      h_q     <= 1'b0;
      f_q     <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        g_q <= g_d;
        h_q <= h_d;
        f_q <= f_d;
      end
    end
  end
  assign out_valid = valid_q;
  assign g         = g_q;
  assign h         = h_q;
  assign f         = f_q;
endmodule

// File: tb/tb_logic_functions.sv
// tb_logic_functions: model-based and literal checks of logic_functions.
module tb_logic_functions;
  logic clk = 1'b0;
  logic rst_n, in_valid, x1, x2, x3, x4;
  logic out_valid, g, h, f;
  int checks = 0;
  int errors = 0;
  int vcount = 0;
  logic m_valid, m_g, m_h, m_f;
  logic g_saved, h_saved, f_saved;

  logic_functions dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .out_valid(out_valid), .g(g), .h(h), .f(f)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluates the equations as integer sums of products.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_g = 1'b0; m_h = 1'b0; m_f = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        int a, b, c, d;
        a = int'(x1); b = int'(x2); c = int'(x3); d = int'(x4);
        m_g = (a * c + b * d) > 0;
        m_h = ((a + (1 - c)) > 0) && (((1 - b) + d) > 0);
        m_f = (m_g + m_h) > 0;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", out_valid, m_valid);
    check("g", g, m_g);
    check("h", h, m_h);
    check("f", f, m_f);
    if (out_valid === 1'b1) vcount++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic setx(input logic [3:0] v, input logic vld);
    {x1, x2, x3, x4} = v;
    in_valid = vld;
  endtask

  task automatic expect4(input string name, input logic v, input logic eg, input logic eh, input logic ef);
    check({name, ".out_valid"}, out_valid, v);
    check({name, ".g"}, g, eg);
    check({name, ".h"}, h, eh);
    check({name, ".f"}, f, ef);
  endtask

  initial begin
    rst_n = 1'b0;
    setx(4'b1111, 1'b1);
    repeat (3) begin
      step();
      expect4("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    setx(4'b1010, 1'b1);
    step();
    expect4("v1010", 1'b1, 1'b1, 1'b1, 1'b1);
    check("model.g1010", m_g, 1'b1);
    check("model.h1010", m_h, 1'b1);
    setx(4'b1010, 1'b0);
    step();
    expect4("hold1010", 1'b0, 1'b1, 1'b1, 1'b1);
    setx(4'b0111, 1'b1);
    step();
    expect4("v0111", 1'b1, 1'b1, 1'b0, 1'b1);
    check("model.h0111", m_h, 1'b0);
    setx(4'b0110, 1'b1);
    step();
    expect4("v0110", 1'b1, 1'b0, 1'b0, 1'b0);
    check("model.f0110", m_f, 1'b0);
    setx(4'b0000, 1'b1);
    step();
    expect4("v0000", 1'b1, 1'b0, 1'b1, 1'b1);
    setx(4'b0000, 1'b0);
    step();
    vcount = 0;
    for (int i = 0; i < 16; i++) begin
      setx(4'(i), 1'b1);
      step();
    end
    setx(4'b0000, 1'b0);
    step();
    checks++;
    if (vcount != 16) begin
      errors++;
      $display("FAIL sweep_valid_count: got %0d expected 16", vcount);
    end
    setx(4'b1010, 1'b1);
    step();
    expect4("pre_rst", 1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    expect4("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    setx(4'b0111, 1'b1);
    step();
    expect4("in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    expect4("post_rst", 1'b1, 1'b1, 1'b0, 1'b1);
    g_saved = g; h_saved = h; f_saved = f;
    repeat (5) begin
      setx(4'($urandom_range(0, 15)), 1'b0);
      step();
      expect4("idle_hold", 1'b0, g_saved, h_saved, f_saved);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
